// File: rtl/tcam_fanout_router.sv
// Multi-bank ternary routing table: each packet is compared against every entry,
// and every hit is emitted (destination, weight, address) one per handshake in ascending address order.
module tcam_fanout_router #(
    parameter int unsigned ID_Width      = 4,
    parameter int unsigned Axon_Width    = 2,
    parameter int unsigned Synapse_Width = 2,
    parameter int unsigned Bits          = ID_Width + Axon_Width + Synapse_Width,
    parameter int unsigned Words         = 16,
    parameter int unsigned AddressSize   = $clog2(Words),
    parameter int unsigned BankSize      = 2,
    parameter int unsigned Weight_Width  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cfg_we,
    input  logic                     cfg_flush,
    output logic                     cfg_ready,
    input  logic [AddressSize-1:0]   cfg_addr,
    input  logic [Bits-1:0]          cfg_data,
    input  logic [Bits-1:0]          cfg_care,
    input  logic                     cfg_vld,
    input  logic [ID_Width-1:0]      cfg_dst,
    input  logic [Weight_Width-1:0]  cfg_weight,
    input  logic [BankSize-1:0]      bank_en,
    input  logic                     pkt_valid,
    output logic                     pkt_ready,
    input  logic [Bits-1:0]          pkt_key,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [ID_Width-1:0]      out_dst,
    output logic [Weight_Width-1:0]  out_weight,
    output logic [AddressSize-1:0]   out_addr,
    output logic                     out_last,
    output logic                     miss,
    output logic [AddressSize:0]     hit_count
);

    localparam int unsigned BankDepth = Words / BankSize;
    localparam int unsigned CntW      = AddressSize + 1;

    typedef enum logic [1:0] {IDLE, MATCH, EMIT} state_t;

    state_t state, state_nxt;

    logic [Bits-1:0]         key_mem    [Words];
    logic [Bits-1:0]         care_mem   [Words];
    logic [ID_Width-1:0]     dst_mem    [Words];
    logic [Weight_Width-1:0] weight_mem [Words];
    logic [Words-1:0]        vld;

    logic [Bits-1:0]         key_q;
    logic [BankSize-1:0]     bank_en_q;
    logic [Words-1:0]        hitline;
    logic [Words-1:0]        pending;
    logic [CntW-1:0]         hit_total;
    logic [CntW-1:0]         hit_cnt_q;
    logic [AddressSize-1:0]  first_addr;
    logic                    is_last;
    logic                    idle;
    logic                    handshake;

    assign idle      = (state == IDLE);
    assign handshake = (state == EMIT) && out_ready;

    // Entry payload RAM; a flush in the same cycle drops the write
    always_ff @(posedge clk) begin
        if (idle && cfg_we && !cfg_flush) begin
            key_mem[cfg_addr]    <= cfg_data;
            care_mem[cfg_addr]   <= cfg_care;
            dst_mem[cfg_addr]    <= cfg_dst;
            weight_mem[cfg_addr] <= cfg_weight;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld <= '0;
        end else if (idle) begin
            if (cfg_flush)
                vld <= '0;
            else if (cfg_we)
                vld[cfg_addr] <= cfg_vld;
        end
    end

    for (genvar g = 0; g < Words; g++) begin : g_cmp
        assign hitline[g] = vld[g] & bank_en_q[g / BankDepth] &
                            (((key_mem[g] ^ key_q) & care_mem[g]) == '0);
    end

    always_comb begin
        hit_total = '0;
        for (int unsigned i = 0; i < Words; i++)
            hit_total = hit_total + CntW'(hitline[AddressSize'(i)]);
    end

    // Lowest pending address wins
    always_comb begin
        first_addr = '0;
        for (int i = Words - 1; i >= 0; i--)
            if (pending[AddressSize'(i)])
                first_addr = AddressSize'(i);
    end

    assign is_last = ((pending & (pending - Words'(1))) == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_q     <= '0;
            bank_en_q <= '0;
            pending   <= '0;
            hit_cnt_q <= '0;
        end else begin
            if (idle && pkt_valid) begin
                key_q     <= pkt_key;
                bank_en_q <= bank_en;
            end
            if (state == MATCH) begin
                pending   <= hitline;
                hit_cnt_q <= hit_total;
            end else if (handshake) begin
                pending <= pending & ~(Words'(1) << first_addr);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (pkt_valid) state_nxt = MATCH;
            MATCH:   state_nxt = (hitline == '0) ? IDLE : EMIT;
            EMIT:    if (out_ready && is_last) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        pkt_ready  = idle;
        cfg_ready  = idle;
        miss       = 1'b0;
        out_valid  = 1'b0;
        out_addr   = '0;
        out_dst    = '0;
        out_weight = '0;
        out_last   = 1'b0;
        hit_count  = '0;
        case (state)
            MATCH: miss = (hitline == '0);
            EMIT: begin
                out_valid  = 1'b1;
                out_addr   = first_addr;
                out_dst    = dst_mem[first_addr];
                out_weight = weight_mem[first_addr];
                out_last   = is_last;
                hit_count  = hit_cnt_q;
            end
            default: ;
        endcase
    end

endmodule
